// File: rtl/mul_product_accumulator.sv
// Accumulates a burst of signed 16-bit multiplier products into a wide signed sum.
// Optional macro MUL_ACC_SAT_EN makes the accumulate saturate instead of wrap.
module mul_product_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic {StAcc, StDone} state_e;

    localparam logic [CNT_W-1:0] CntCap = '1;
    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum_raw;
    logic [ACC_W-1:0]   sum_next;
    logic [CNT_W-1:0]   cnt_inc;
    logic               add_ovf;
    logic               accept;
    logic               at_cap;

    // rst_n gates in_ready so nothing is offered as accepted while in reset
    assign in_ready = (state_q == StAcc) && !clear && rst_n;
    assign accept   = in_valid && in_ready;

    assign addend  = ACC_W'($signed(in_product));
    assign sum_raw = acc_q + addend;
    assign add_ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) &&
                     (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MUL_ACC_SAT_EN
    // Operands share a sign on overflow, so acc's sign picks the rail
    assign sum_next = add_ovf ? (acc_q[ACC_W-1] ? AccMin : AccMax) : sum_raw;
`else
    assign sum_next = sum_raw;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign at_cap  = (cnt_inc == CntCap);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = StAcc;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StAcc: begin
                    if (accept) begin
                        acc_d = sum_next;
                        cnt_d = cnt_inc;
                        ovf_d = ovf_q | add_ovf;
                        if (in_last || at_cap) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StAcc;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = StAcc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator driven in lockstep with
// directed bursts; a monitor checks each handed-off result against a queue.
module tb_mul_product_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_b;
    logic [15:0] in_product;
    logic        in_last;
    logic        out_valid;
    logic        out_valid_b;
    logic        out_ready;
    logic [23:0] out_sum;
    logic [15:0] out_sum_b;
    logic [3:0]  out_count;
    logic [3:0]  out_count_b;
    logic        out_ovf;
    logic        out_ovf_b;

    typedef struct {
        logic [23:0] s24;
        logic [15:0] s16;
        logic [3:0]  cnt;
        logic        o24;
        logic        o16;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mul_product_accumulator #(.ACC_W(24), .CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_ovf    (out_ovf)
    );

    mul_product_accumulator #(.ACC_W(16), .CNT_W(4)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready_b),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_sum    (out_sum_b),
        .out_count  (out_count_b),
        .out_ovf    (out_ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [23:0] s24, input logic [15:0] s16, input logic [3:0] cnt,
                        input logic o24, input logic o16);
        exp_t e;
        e.s24 = s24; e.s16 = s16; e.cnt = cnt; e.o24 = o24; e.o16 = o16;
        exp_q.push_back(e);
    endtask

    // Entered and left at posedge+1
    task automatic beat(input logic [15:0] p, input logic last);
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        @(negedge clk);
        for (int n = 0; n < 40 && !in_ready; n++) @(negedge clk);
        check("beat_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Entered at posedge+1 so the monitor sees the handshake at the next negedge
    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum24", 32'(out_sum), 32'(e.s24));
                check("sum16", 32'(out_sum_b), 32'(e.s16));
                check("count24", 32'(out_count), 32'(e.cnt));
                check("count16", 32'(out_count_b), 32'(e.cnt));
                check("ovf24", 32'(out_ovf), 32'(e.o24));
                check("ovf16", 32'(out_ovf_b), 32'(e.o16));
                check("valid16", 32'(out_valid_b), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        in_valid   = 1'b1;
        in_product = 16'h0001;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        // Reset held with in_valid high
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", 32'(in_ready), 32'd1);
        step();

        // Basic burst with a held result
        beat(16'h0064, 1'b0);
        beat(16'hFF9C, 1'b0);
        beat(16'h7FFF, 1'b1);
        @(negedge clk);
        check("basic_latency_valid", 32'(out_valid), 32'd1);
        check("basic_sum", 32'(out_sum), 32'h007FFF);
        check("basic_count", 32'(out_count), 32'd3);
        check("basic_ovf", 32'(out_ovf), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(out_sum), 32'h007FFF);
            check("hold_count", 32'(out_count), 32'd3);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        step();
        push(24'h007FFF, 16'h7FFF, 4'd3, 1'b0, 1'b0);
        drain();

        // Positive overflow: 16-bit instance wraps or saturates
        beat(16'h7FFF, 1'b0);
        beat(16'h0001, 1'b1);
`ifdef MUL_ACC_SAT_EN
        push(24'h008000, 16'h7FFF, 4'd2, 1'b0, 1'b1);
`else
        push(24'h008000, 16'h8000, 4'd2, 1'b0, 1'b1);
`endif
        drain();

        // Negative overflow
        beat(16'h8000, 1'b0);
        beat(16'hFFFF, 1'b1);
`ifdef MUL_ACC_SAT_EN
        push(24'hFF7FFF, 16'h8000, 4'd2, 1'b0, 1'b1);
`else
        push(24'hFF7FFF, 16'h7FFF, 4'd2, 1'b0, 1'b1);
`endif
        drain();

        // Count cap closes the burst at 15 beats
        for (int i = 0; i < 15; i++) beat(16'h0001, 1'b0);
        in_valid   = 1'b1;
        in_product = 16'h0001;
        @(negedge clk);
        check("cap_stall_ready", 32'(in_ready), 32'd0);
        check("cap_valid", 32'(out_valid), 32'd1);
        check("cap_count", 32'(out_count), 32'd15);
        in_valid = 1'b0;
        step();
        push(24'd15, 16'd15, 4'd15, 1'b0, 1'b0);
        drain();

        // Back-to-back bursts with out_ready and in_valid held high
        out_ready = 1'b1;
        push(24'd5, 16'd5, 4'd1, 1'b0, 1'b0);
        beat(16'h0005, 1'b1);
        in_valid   = 1'b1;
        in_product = 16'h0003;
        in_last    = 1'b1;
        @(negedge clk);
        check("b2b_gap_ready", 32'(in_ready), 32'd0);
        push(24'd3, 16'd3, 4'd1, 1'b0, 1'b0);
        step();
        beat(16'h0003, 1'b1);
        @(negedge clk);
        step();
        out_ready = 1'b0;

        // Clear mid-burst drops the partial sum and the presented beat
        beat(16'h0010, 1'b0);
        beat(16'h0010, 1'b0);
        clear      = 1'b1;
        in_valid   = 1'b1;
        in_product = 16'h0010;
        in_last    = 1'b1;
        @(negedge clk);
        check("clear_in_ready", 32'(in_ready), 32'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("clear_sum", 32'(out_sum), 32'd0);
        check("clear_count", 32'(out_count), 32'd0);
        check("clear_valid", 32'(out_valid), 32'd0);
        step();
        push(24'd1, 16'd1, 4'd1, 1'b0, 1'b0);
        beat(16'h0001, 1'b1);
        drain();

        // Clear in DONE discards the pending result
        beat(16'h0007, 1'b1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        check("discard_valid", 32'(out_valid), 32'd0);
        check("discard_sum", 32'(out_sum), 32'd0);
        step();

        // Asynchronous reset mid-burst
        beat(16'h0010, 1'b0);
        beat(16'h0010, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", 32'(out_sum), 32'd0);
        check("async_rst_count", 32'(out_count), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        push(24'd1, 16'd1, 4'd1, 1'b0, 1'b0);
        beat(16'h0001, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mul_product_accumulator.md
# mul_product_accumulator

Downstream consumer of the 8x8 signed multiplier's 16-bit two's-complement `product`. Accepts one product per cycle over a valid/ready handshake and accumulates a burst of products into a wide signed sum. When the burst ends it presents the sum, beat count and overflow flag on an output handshake. It forms the accumulate half of the ALU's multiply-accumulate path.

## Interface
- `ACC_W`, 24: accumulator and `out_sum` width in bits; legal range 16 to 32.
- `CNT_W`, 4: beat counter width; maximum burst is 2^CNT_W-1 beats.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort/flush, highest priority after reset.
- `in_valid`  in  1  `in_product` valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_product`  in  16  signed product from the multiplier.
- `in_last`  in  1  qualifies the final beat of a burst.
- `out_valid`  out  1  burst result available.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  ACC_W  signed accumulated sum.
- `out_count`  out  CNT_W  beats accumulated in this burst.
- `out_ovf`  out  1  sticky overflow seen during the burst.

## Operation
- FSM states:
  - ACC: collecting beats.
  - DONE: result held.
- Reset state is ACC. The registers `acc`, `cnt` and `ovf` reset to 0.
- Output assignments:
  - `in_ready` = (state==ACC) & !clear & rst_n.
  - `out_valid` = (state==DONE).
  - `out_sum`, `out_count` and `out_ovf` drive the `acc`, `cnt` and `ovf` registers directly.
- A beat is accepted when `in_valid & in_ready`. On acceptance:
  - `acc` <= acc + sign-extend(in_product to ACC_W).
  - `cnt` <= cnt+1.
  - `ovf` <= ovf | signed-overflow of that add. Overflow means both operand signs are equal and the result sign differs.
- Transition ACC->DONE on an accepted beat when `in_last`=1, or when `cnt`+1 == 2^CNT_W-1 (forced close at the count cap).
- In DONE, `in_ready`=0. On `out_ready`, go to ACC and zero `acc`, `cnt` and `ovf` in the same edge.
- `clear`=1 in any state:
  - next state ACC; `acc`, `cnt` and `ovf` zeroed.
  - a beat presented that cycle is not accepted.
  - a pending result is discarded.
- `in_valid` high with `in_last` is the only way to end a burst before the cap. `in_last` without `in_valid` is ignored.
- A zero-length burst is impossible; `out_count` ≥ 1 whenever `out_valid`=1.
- Default behaviour (no macro): the add wraps modulo 2^ACC_W.

## Timing
- Reset values:
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready`=0 while `rst_n` is low, and 1 from the first cycle after release.
- Latency: a last beat accepted at edge N gives `out_valid`=1 and the final sum after edge N.
- Throughput:
  - 1 beat/cycle within a burst.
  - at least one bubble between bursts, because `in_ready`=0 during DONE, including the cycle in which `out_ready` is sampled.
- While `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- `rst_n` assertion mid-burst or in DONE: outputs go immediately (asynchronously) to their reset values.

## Configuration
- `MUL_ACC_SAT_EN`
  - Defined: on a signed overflow the add saturates `acc` to +2^(ACC_W-1)-1 or -2^(ACC_W-1), following the sign of the operands, and `ovf` is set. Later beats add from the saturated value.
  - Undefined: the add wraps modulo 2^ACC_W and `ovf` is still set. The `ovf` flag behaves identically in both builds.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1. Required: `in_ready`=0, `out_valid`=0, `out_sum`=0. After release, `in_ready`=1 on the next cycle.
- Basic burst (ACC_W=24): beats 0x0064, 0xFF9C, then 0x7FFF with `in_last`. Required:
  - one cycle after the last beat, `out_valid`=1, `out_sum`=0x007FFF, `out_count`=3, `out_ovf`=0.
  - with `out_ready` held low for 5 cycles, outputs stay stable and `in_ready`=0.
- Overflow (ACC_W=16): beats 0x7FFF, then 0x0001 with `in_last`. Required:
  - without the macro: `out_sum`=0x8000, `out_ovf`=1.
  - with `MUL_ACC_SAT_EN`: `out_sum`=0x7FFF, `out_ovf`=1.
- Count cap (CNT_W=4): 15 beats of 0x0001 with `in_last` never set. Required: `out_valid` after the 15th beat with `out_sum`=15 and `out_count`=15. The 16th beat is stalled by `in_ready`=0.
- Back-to-back: complete a burst with `out_ready`=1, keeping `in_valid` high. Required: one-cycle `in_ready` gap, and the next burst starts from `acc`=0.
- Abort:
  - `clear` after 2 beats of 0x0010: the next burst of 0x0001 with `in_last` must give `out_sum`=1, `out_count`=1.
  - pulse `rst_n` low mid-burst: identical result.
